serial_compare_ctrl: RTL and testbench
======================================

# serial_compare_ctrl

Sequential controller that compares two N-bit unsigned operands with a single shared 2-bit comparator cell. It walks 2-bit slices MSB-first, one per clock, and stops at the first unequal slice. It reports GT/EQ/LT with a start/busy/done handshake. It is the area-reduced, multi-cycle alternative to the fully unrolled N-bit comparator chain, for datapaths that can tolerate variable latency.

## Interface
- N, 16, operand width; must be even and ≥ 2; number of slices S = N/2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a comparison; sampled only in IDLE
- A  in  N  operand A, unsigned; captured on accepted start
- B  in  N  operand B, unsigned; captured on accepted start
- busy  out  1  high in COMPARE and DONE states
- done  out  1  one-cycle pulse; result valid this cycle
- GT  out  1  A > B
- EQ  out  1  A == B
- LT  out  1  A < B
- steps  out  $clog2(S)+1  number of slice compares performed by the last comparison (1..S)

## Operation
- Slice j covers bits [N-1-2j -: 2]; slice 0 is the most significant. It compares through one instance of the team's 2-bit comparator cell (A, B, GT, EQ ports); LT = !GT & !EQ.
- Registers: opA, opB (N each), idx (slice index), state, result flags, steps.
- **IDLE**
  - busy = 0.
  - On start = 1: latch A→opA and B→opB, set idx = 0, clear GT/EQ/LT/steps to 0, go to COMPARE.
  - With start = 0: stay in IDLE.
- **COMPARE** (one slice per cycle)
  - Slice idx unequal: set GT = cell.GT, LT = !cell.GT, EQ = 0, steps = idx+1, go to DONE.
  - Slice equal and idx == S-1: set EQ = 1, GT = LT = 0, steps = S, go to DONE.
  - Slice equal otherwise: idx ← idx+1, stay in COMPARE.
- **DONE**
  - done = 1 for exactly this cycle, then go to IDLE.
- GT/EQ/LT/steps hold their values after DONE until the next accepted start clears them.
- Exactly one of GT/EQ/LT is 1 whenever done = 1.
- start is ignored in COMPARE and DONE. A/B changes after capture have no effect.
- Back-to-back operation: the earliest next start is accepted in the IDLE cycle following done.

## Timing
- Reset values:
  - state = IDLE.
  - busy = done = GT = EQ = LT = 0.
  - steps = 0, idx = 0, opA = opB = 0.
- rst has priority over all transitions. Asserting it mid-COMPARE or in DONE aborts the operation in the next cycle: no done pulse, all outputs return to reset values.
- Let start be accepted at edge k. COMPARE evaluates slice 0 in cycle k+1.
- First mismatch at slice j: done is high in cycle k+2+j. Latency is j+2 cycles; steps = j+1.
- Equal operands: done in cycle k+1+S. Latency is S+1 cycles; steps = S.
- busy rises in cycle k+1 and falls after the done cycle. It is never high in IDLE.
- Minimum start-to-start period: j+3 cycles.
- All outputs are registered. No combinational path from A/B/start to any output.

## Test plan
- **Reset:** hold rst 2 cycles with random A/B/start → busy = done = GT = EQ = LT = 0, steps = 0; no done pulse for the following 20 idle cycles.
- **MSB mismatch:** N=16, A=16'h8000, B=16'h7FFF, start 1 cycle → done exactly 2 cycles after start, GT=1, EQ=0, LT=0, steps=1, busy high for 2 cycles.
- **Equal operands:** A=B=16'h1234 → done 9 cycles after start, EQ=1, GT=LT=0, steps=8; result flags stay stable for 5 idle cycles afterward.
- **LSB mismatch:** A=16'h0001, B=16'h0002 → LT=1, steps=8, done 9 cycles after start.
- **Ignored inputs while busy:** start A=16'h00F0, B=16'h00E0; during COMPARE, drive start=1 and A=0, B=16'hFFFF every cycle → single done pulse, GT=1, steps=6; a new start is accepted only in the cycle after done.
- **Reset mid-operation:** start A=B=16'hFFFF, assert rst in the third COMPARE cycle → no done, outputs at reset values the next cycle. Then start A=16'h0000, B=16'h4000 → LT=1, steps=1, done 2 cycles after start.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// Multi-cycle unsigned magnitude comparator: walks 2-bit slices MSB-first through
// one shared comparator cell and stops at the first unequal slice.

module CompareCell2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       gt_o,
    output logic       eq_o
);
    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);
endmodule

module serial_compare_ctrl #(
    parameter int N = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [N-1:0]           a_i,
    input  logic [N-1:0]           b_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   gt_o,
    output logic                   eq_o,
    output logic                   lt_o,
    output logic [$clog2(N/2):0]   steps_o
);
    localparam int S  = N / 2;
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam int SW = $clog2(S) + 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   opA_q, opA_d;
    logic [N-1:0]   opB_q, opB_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           gt_q, gt_d;
    logic           eq_q, eq_d;
    logic           lt_q, lt_d;
    logic [SW-1:0]  steps_q, steps_d;

    logic [N-1:0]   shiftA, shiftB;
    logic           cellGt, cellEq;

    // Shifting the current slice to the top keeps the select index-free.
    assign shiftA = opA_q << {idx_q, 1'b0};
    assign shiftB = opB_q << {idx_q, 1'b0};

    CompareCell2 uCell (
        .a_i  (shiftA[N-1 -: 2]),
        .b_i  (shiftB[N-1 -: 2]),
        .gt_o (cellGt),
        .eq_o (cellEq)
    );

    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        steps_d = steps_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    opA_d   = a_i;
                    opB_d   = b_i;
                    idx_d   = '0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    steps_d = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (!cellEq) begin
                    gt_d    = cellGt;
                    lt_d    = !cellGt;
                    eq_d    = 1'b0;
                    steps_d = SW'(idx_q) + SW'(1);
                    state_d = DONE;
                end else if (idx_q == IW'(S - 1)) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    steps_d = SW'(S);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            steps_q <= steps_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign gt_o    = gt_q;
    assign eq_o    = eq_q;
    assign lt_o    = lt_q;
    assign steps_o = steps_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl (N=16): latency, result flags, steps,
// ignored inputs while busy and reset abort.

module tb_serial_compare_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic        gt;
    logic        eq;
    logic        lt;
    logic [3:0]  steps;
    logic [8:0]  obs;

    int testsRun    = 0;
    int testsFailed = 0;

    serial_compare_ctrl #(.N(16)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (opA),
        .b_i     (opB),
        .busy_o  (busy),
        .done_o  (done),
        .gt_o    (gt),
        .eq_o    (eq),
        .lt_o    (lt),
        .steps_o (steps)
    );

    // Packed observation: {busy, done, gt, eq, lt, steps[3:0]}
    assign obs = {busy, done, gt, eq, lt, steps};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulses start for one edge; returns on the negedge after the accepting edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        opA   = a;
        opB   = b;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        int doneCnt;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom);
            opA   = 16'($urandom);
            opB   = 16'($urandom);
            tick();
        end
        testsRun++;
        if (obs !== 9'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %b want %b", obs, 9'h000);
        end
        rst = 1'b0;
        start = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            doneCnt += int'(done);
        end
        testsRun++;
        if (doneCnt !== 0 || obs !== 9'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_idle: got doneCnt=%0d obs=%b want 0 / %b", doneCnt, obs, 9'h000);
        end
    endtask

    task automatic test_msb_mismatch();
        int cnt;
        int busyCnt;
        launch(16'h8000, 16'h7FFF);
        cnt = 1;
        busyCnt = 0;
        while (!done && cnt < 20) begin
            busyCnt += int'(busy);
            tick();
            cnt++;
        end
        busyCnt += int'(busy);
        testsRun++;
        if (cnt !== 2) begin
            testsFailed++;
            $display("[TB] FAIL msb_latency: got %0d want 2", cnt);
        end
        testsRun++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1}) begin
            testsFailed++;
            $display("[TB] FAIL msb_result: got %b want %b", obs, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1});
        end
        tick();
        testsRun++;
        if (busyCnt !== 2 || obs !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}) begin
            testsFailed++;
            $display("[TB] FAIL msb_after: got busyCnt=%0d obs=%b want 2 / %b",
                     busyCnt, obs, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1});
        end
    endtask

    task automatic test_equal();
        int cnt;
        launch(16'h1234, 16'h1234);
        cnt = 1;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        testsRun++;
        if (cnt !== 9 || obs !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8}) begin
            testsFailed++;
            $display("[TB] FAIL equal_result: got cnt=%0d obs=%b want 9 / %b",
                     cnt, obs, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            testsRun++;
            if (obs !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8}) begin
                testsFailed++;
                $display("[TB] FAIL equal_hold%0d: got %b want %b", i, obs,
                         {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8});
            end
        end
    endtask

    task automatic test_lsb_mismatch();
        int cnt;
        launch(16'h0001, 16'h0002);
        cnt = 1;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        testsRun++;
        if (cnt !== 9 || obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8}) begin
            testsFailed++;
            $display("[TB] FAIL lsb_result: got cnt=%0d obs=%b want 9 / %b",
                     cnt, obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8});
        end
        tick();
    endtask

    // start stays high throughout, so the next op is accepted right after DONE.
    task automatic test_back_to_back();
        int cnt;
        start = 1'b1;
        opA   = 16'h00F0;
        opB   = 16'h00E0;
        tick();
        opA = 16'h0000;
        opB = 16'hFFFF;
        cnt = 1;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        testsRun++;
        if (cnt !== 7 || obs !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6}) begin
            testsFailed++;
            $display("[TB] FAIL ignored_result: got cnt=%0d obs=%b want 7 / %b",
                     cnt, obs, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6});
        end
        tick();
        testsRun++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_idle: got %b want %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6});
        end
        tick();
        start = 1'b0;
        testsRun++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_accept: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        end
        tick();
        testsRun++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_result: got %b want %b", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int cnt;
        int doneCnt;
        launch(16'hFFFF, 16'hFFFF);
        tick();
        tick();
        rst = 1'b1;
        tick();
        testsRun++;
        if (obs !== 9'h000) begin
            testsFailed++;
            $display("[TB] FAIL abort_outputs: got %b want %b", obs, 9'h000);
        end
        rst = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            doneCnt += int'(done);
        end
        testsRun++;
        if (doneCnt !== 0) begin
            testsFailed++;
            $display("[TB] FAIL abort_no_done: got %0d want 0", doneCnt);
        end
        launch(16'h0000, 16'h4000);
        cnt = 1;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        testsRun++;
        if (cnt !== 2 || obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1}) begin
            testsFailed++;
            $display("[TB] FAIL after_abort: got cnt=%0d obs=%b want 2 / %b",
                     cnt, obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1});
        end
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        opA   = '0;
        opB   = '0;
        @(negedge clk);
        test_reset();
        test_msb_mismatch();
        test_equal();
        test_lsb_mismatch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
